mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
- Accumulate stage that sits directly downstream of the 4x4 array multiplier in the MAC datapath.
- Accepts one unsigned 8-bit product per valid/ready beat and sums LEN consecutive products into a wide accumulator.
- After the LEN-th product, presents the sum on a valid/ready output port with a sticky overflow flag, then rearms for the next dot product.

Parameters:
- PROD_W, 8: product width from the multiplier; must be >= 1.
- ACC_W, 16: accumulator and result width; must be >= PROD_W.
- LEN, 4: products per accumulation (dot-product length); must be >= 1.
- SATURATE, 1: 1 = clamp at 2^ACC_W-1 on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- clr  in  1  synchronous abort/clear, active-high.
- in_valid  in  1  product beat valid.
- in_ready  out  1  stage can accept a product.
- in_prod  in  PROD_W  unsigned product (multiplier z output).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_acc  out  ACC_W  accumulated sum.
- out_ovf  out  1  overflow occurred during this accumulation.
- beat_cnt  out  clog2(LEN+1)  products accepted in the current accumulation.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, acc=0, beat_cnt=0, ovf=0, out_valid=0, out_acc=0, out_ovf=0. Any reset mid-operation discards the partial sum.
- States:
  - IDLE: beat_cnt=0, acc=0.
  - ACC: 0 < beat_cnt < LEN.
  - DONE: result held.
- in_ready = !clr && (state != DONE). This is combinational; no other input affects it.
- Accept: in_valid && in_ready at a rising edge.
  - sum = acc + zero-extended in_prod, computed at ACC_W+1 bits.
  - If sum[ACC_W]=1: ovf<=1 and acc<=all ones (SATURATE=1) or acc<=sum[ACC_W-1:0] (SATURATE=0).
  - Otherwise acc<=sum.
  - beat_cnt increments.
- Transitions:
  - IDLE -> ACC on accept when LEN>1.
  - ACC stays in ACC on accept while new beat_cnt < LEN.
  - Accept making beat_cnt == LEN, from IDLE when LEN=1 or from ACC: go to DONE.
- On entering DONE:
  - out_valid=1, out_acc=updated acc, out_ovf=updated ovf. Latency is 1 cycle after the last accept.
  - beat_cnt reads LEN.
- DONE:
  - out_valid, out_acc, out_ovf are held stable until out_ready=1.
  - in_ready=0, so upstream stalls (backpressure).
- Output handshake: out_valid && out_ready at an edge.
  - Next cycle: state=IDLE, acc=0, ovf=0, beat_cnt=0, out_valid=0.
  - out_acc and out_ovf retain the last values.
  - in_ready rises in that same next cycle, giving one bubble cycle between dot products.
- Saturation is sticky: once acc is all ones with SATURATE=1, further adds keep it all ones.
- clr=1 at an edge (priority over accept and output handshake):
  - state=IDLE, acc=0, ovf=0, beat_cnt=0, out_valid=0.
  - A concurrent input beat is not accepted (in_ready=0). A pending result in DONE is dropped.
- in_valid=0 in IDLE or ACC: all state holds; there is no timeout.
- in_prod is ignored when in_valid=0. There is no X-propagation requirement.

Test Plan:
1. Defaults (ACC_W=16, LEN=4, SATURATE=1):
   - Stimulus: 4 back-to-back beats of 225 (15*15), out_ready=1.
   - Required: out_valid one cycle after the 4th accept; out_acc=0x0384 (900); out_ovf=0; beat_cnt sequence 0,1,2,3,4,0.
2. Saturation (ACC_W=10, LEN=5, SATURATE=1):
   - Stimulus: 5 beats of 225.
   - Required: out_acc=1023; out_ovf=1. Same run with SATURATE=0 -> out_acc=101; out_ovf=1.
3. Backpressure (defaults):
   - Stimulus: after the result, hold out_ready=0 for 3 cycles with in_valid=1, in_prod=1.
   - Required: in_ready=0 and out_acc=900 stable for those 3 cycles.
   - Stimulus: raise out_ready.
   - Required: out_valid=0 next cycle and in_ready=1; the next 4 beats of 1 give out_acc=4.
4. Mid-stream clr (defaults):
   - Stimulus: accept 2 beats of 100, then clr=1 for 1 cycle with in_valid=1, in_prod=50.
   - Required: the beat is not accepted; beat_cnt=0.
   - Stimulus: 4 beats of 10.
   - Required: out_acc=40; out_ovf=0.
5. Async reset mid-operation:
   - Stimulus: after 3 beats, pulse rst_n low between clock edges.
   - Required: outputs zero immediately (asynchronously, without waiting for a clock edge).
   - Stimulus: resume with 4 beats of 2.
   - Required: out_acc=8.
6. Gapped input, LEN=1 variant:
   - Defaults with in_valid toggling every other cycle -> same result as scenario 1.
   - LEN=1, beat of 37 -> out_valid next cycle with out_acc=37; in_ready=0 until the result handshake.

Source files
------------

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums LEN unsigned products from the array multiplier into a
// wide accumulator and hands the result downstream over a valid/ready port,
// with a sticky overflow flag and optional saturation.
module mac_accumulator #(
    parameter int unsigned PROD_W   = 8,
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned LEN      = 4,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PROD_W-1:0]            in_prod,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_acc,
    output logic                         out_ovf,
    output logic [$clog2(LEN+1)-1:0]     beat_cnt
);

    localparam int unsigned CNT_W = $clog2(LEN + 1);
    localparam int unsigned SUM_W = ACC_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_n;
    logic             ovf;
    logic             ovf_n;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             out_valid_n;
    logic [ACC_W-1:0] out_acc_n;
    logic             out_ovf_n;
    logic [SUM_W-1:0] sum;
    logic             accept;

    // Upstream may push whenever no result is pending and no clear is requested.
    assign in_ready = !clr && (state != S_DONE);
    assign accept   = in_valid && in_ready;
    // One extra bit so the carry out of the accumulator is visible as overflow.
    assign sum      = SUM_W'(acc) + SUM_W'(in_prod);
    assign cnt_inc  = beat_cnt + CNT_W'(1);

    // Next-state and next-register values; clr overrides everything else.
    always_comb begin
        state_n     = state;
        acc_n       = acc;
        ovf_n       = ovf;
        cnt_n       = beat_cnt;
        out_valid_n = out_valid;
        out_acc_n   = out_acc;
        out_ovf_n   = out_ovf;
        if (clr) begin
            state_n     = S_IDLE;
            acc_n       = '0;
            ovf_n       = 1'b0;
            cnt_n       = '0;
            out_valid_n = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACC: begin
                    if (accept) begin
                        if (sum[ACC_W]) begin
                            ovf_n = 1'b1;
                            acc_n = SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
                        end else begin
                            acc_n = sum[ACC_W-1:0];
                        end
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_W'(LEN)) begin
                            state_n     = S_DONE;
                            out_valid_n = 1'b1;
                            out_acc_n   = acc_n;
                            out_ovf_n   = ovf_n;
                        end else begin
                            state_n = S_ACC;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_n     = S_IDLE;
                        acc_n       = '0;
                        ovf_n       = 1'b0;
                        cnt_n       = '0;
                        out_valid_n = 1'b0;
                    end
                end
                default: begin
                    state_n     = S_IDLE;
                    acc_n       = '0;
                    ovf_n       = 1'b0;
                    cnt_n       = '0;
                    out_valid_n = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset discards any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            ovf       <= ovf_n;
            beat_cnt  <= cnt_n;
            out_valid <= out_valid_n;
            out_acc   <= out_acc_n;
            out_ovf   <= out_ovf_n;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: four configurations share one stimulus bus, a
// per-instance enable gates in_valid, and an arithmetic reference model checks
// every instance every cycle alongside directed per-cycle vector tables.
module tb_mac_accumulator;

    localparam int NI = 4;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic [7:0]    in_prod;
    logic          out_ready;
    logic [NI-1:0] en;

    // instance 0: defaults; 1: W10 L5 sat; 2: W10 L5 wrap; 3: L1
    logic        a_ir, a_ov, a_ovf;  logic [15:0] a_acc; logic [2:0] a_cnt;
    logic        b_ir, b_ov, b_ovf;  logic [9:0]  b_acc; logic [2:0] b_cnt;
    logic        c_ir, c_ov, c_ovf;  logic [9:0]  c_acc; logic [2:0] c_cnt;
    logic        d_ir, d_ov, d_ovf;  logic [15:0] d_acc; logic [0:0] d_cnt;

    mac_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(4), .SATURATE(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid & en[0]), .in_ready(a_ir),
        .in_prod(in_prod), .out_valid(a_ov), .out_ready(out_ready), .out_acc(a_acc),
        .out_ovf(a_ovf), .beat_cnt(a_cnt));
    mac_accumulator #(.PROD_W(8), .ACC_W(10), .LEN(5), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid & en[1]), .in_ready(b_ir),
        .in_prod(in_prod), .out_valid(b_ov), .out_ready(out_ready), .out_acc(b_acc),
        .out_ovf(b_ovf), .beat_cnt(b_cnt));
    mac_accumulator #(.PROD_W(8), .ACC_W(10), .LEN(5), .SATURATE(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid & en[2]), .in_ready(c_ir),
        .in_prod(in_prod), .out_valid(c_ov), .out_ready(out_ready), .out_acc(c_acc),
        .out_ovf(c_ovf), .beat_cnt(c_cnt));
    mac_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(1), .SATURATE(1'b1)) u_d (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid & en[3]), .in_ready(d_ir),
        .in_prod(in_prod), .out_valid(d_ov), .out_ready(out_ready), .out_acc(d_acc),
        .out_ovf(d_ovf), .beat_cnt(d_cnt));

    // Uniform views of all instance outputs
    logic        ir_v  [NI];
    logic        ov_v  [NI];
    logic        ovf_v [NI];
    logic [15:0] acc_v [NI];
    logic [2:0]  cnt_v [NI];

    assign ir_v[0] = a_ir;  assign ov_v[0] = a_ov;  assign ovf_v[0] = a_ovf;
    assign ir_v[1] = b_ir;  assign ov_v[1] = b_ov;  assign ovf_v[1] = b_ovf;
    assign ir_v[2] = c_ir;  assign ov_v[2] = c_ov;  assign ovf_v[2] = c_ovf;
    assign ir_v[3] = d_ir;  assign ov_v[3] = d_ov;  assign ovf_v[3] = d_ovf;
    assign acc_v[0] = a_acc;
    assign acc_v[1] = 16'(b_acc);
    assign acc_v[2] = 16'(c_acc);
    assign acc_v[3] = d_acc;
    assign cnt_v[0] = a_cnt;
    assign cnt_v[1] = b_cnt;
    assign cnt_v[2] = c_cnt;
    assign cnt_v[3] = 3'(d_cnt);

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int len_of(input int i);
        case (i)
            0: return 4;
            1: return 5;
            2: return 5;
            default: return 1;
        endcase
    endfunction

    function automatic int width_of(input int i);
        return (i == 1 || i == 2) ? 10 : 16;
    endfunction

    function automatic bit sat_of(input int i);
        return (i != 2);
    endfunction

    // Reference model: a dot product in progress or a result waiting to leave
    bit     m_done [NI];
    int     m_cnt  [NI];
    longint m_acc  [NI];
    bit     m_ovf  [NI];
    longint m_oacc [NI];
    bit     m_oovf [NI];

    always @(posedge clk or negedge rst_n) begin
        longint full;
        longint s;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_done[i] = 0; m_cnt[i] = 0; m_acc[i] = 0; m_ovf[i] = 0;
                m_oacc[i] = 0; m_oovf[i] = 0;
            end else if (clr) begin
                m_done[i] = 0; m_cnt[i] = 0; m_acc[i] = 0; m_ovf[i] = 0;
            end else if (m_done[i]) begin
                if (out_ready) begin
                    m_done[i] = 0; m_cnt[i] = 0; m_acc[i] = 0; m_ovf[i] = 0;
                end
            end else if (in_valid && en[i]) begin
                full = (longint'(1) << width_of(i)) - 1;
                s    = m_acc[i] + longint'(in_prod);
                if (s > full) begin
                    m_ovf[i] = 1;
                    m_acc[i] = sat_of(i) ? full : s - (full + 1);
                end else begin
                    m_acc[i] = s;
                end
                m_cnt[i]++;
                if (m_cnt[i] == len_of(i)) begin
                    m_done[i] = 1;
                    m_oacc[i] = m_acc[i];
                    m_oovf[i] = m_ovf[i];
                end
            end
        end
    end

    // Compare every instance against the model just after each rising edge
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("model%0d.out_valid", i), longint'(ov_v[i]), longint'(m_done[i]));
                chk($sformatf("model%0d.out_acc", i), longint'(acc_v[i]), m_oacc[i]);
                chk($sformatf("model%0d.out_ovf", i), longint'(ovf_v[i]), longint'(m_oovf[i]));
                chk($sformatf("model%0d.beat_cnt", i), longint'(cnt_v[i]), longint'(m_cnt[i]));
                chk($sformatf("model%0d.in_ready", i), longint'(ir_v[i]),
                    longint'(!clr && !m_done[i]));
            end
        end
    end

    // One directed cycle: inputs applied, expected registered/comb outputs before the edge
    typedef struct {
        int  inst;
        bit  v;
        int  p;
        bit  c;
        bit  r;
        bit  e_ov;
        int  e_acc;
        bit  e_ovf;
        int  e_cnt;
        bit  e_ir;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int inst, input bit v, input int p, input bit c, input bit r,
                       input bit e_ov, input int e_acc, input bit e_ovf, input int e_cnt,
                       input bit e_ir);
        vec_t t;
        t.inst = inst; t.v = v; t.p = p; t.c = c; t.r = r;
        t.e_ov = e_ov; t.e_acc = e_acc; t.e_ovf = e_ovf; t.e_cnt = e_cnt; t.e_ir = e_ir;
        vq.push_back(t);
    endtask

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0; en = '0;
        #5 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset%0d.out_valid", i), longint'(ov_v[i]), 0);
            chk($sformatf("reset%0d.out_acc", i), longint'(acc_v[i]), 0);
            chk($sformatf("reset%0d.out_ovf", i), longint'(ovf_v[i]), 0);
            chk($sformatf("reset%0d.beat_cnt", i), longint'(cnt_v[i]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back 4 x 225 -> 900, count 0..4 then 0
        for (int k = 0; k < 4; k++) add(0, 1, 225, 0, 1, 0, 0, 0, k, 1);
        add(0, 0, 0, 0, 1, 1, 900, 0, 4, 0);
        add(0, 0, 0, 0, 1, 0, 900, 0, 0, 1);
        // Backpressure: result held three cycles, upstream stalled
        for (int k = 0; k < 4; k++) add(0, 1, 225, 0, 0, 0, 900, 0, k, 1);
        for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 0, 1, 900, 0, 4, 0);
        add(0, 1, 1, 0, 1, 1, 900, 0, 4, 0);
        for (int k = 0; k < 4; k++) add(0, 1, 1, 0, 1, 0, 900, 0, k, 1);
        add(0, 0, 0, 0, 1, 1, 4, 0, 4, 0);
        add(0, 0, 0, 0, 1, 0, 4, 0, 0, 1);
        // Mid-stream clear drops the partial sum and the concurrent beat
        add(0, 1, 100, 0, 1, 0, 4, 0, 0, 1);
        add(0, 1, 100, 0, 1, 0, 4, 0, 1, 1);
        add(0, 1, 50, 1, 1, 0, 4, 0, 2, 0);
        for (int k = 0; k < 4; k++) add(0, 1, 10, 0, 1, 0, 4, 0, k, 1);
        add(0, 0, 0, 0, 1, 1, 40, 0, 4, 0);
        add(0, 0, 0, 0, 1, 0, 40, 0, 0, 1);
        // Gapped input gives the same 900
        for (int k = 0; k < 4; k++) begin
            add(0, 1, 225, 0, 1, 0, 40, 0, k, 1);
            if (k < 3) add(0, 0, 0, 0, 1, 0, 40, 0, k + 1, 1);
        end
        add(0, 0, 0, 0, 1, 1, 900, 0, 4, 0);
        add(0, 0, 0, 0, 1, 0, 900, 0, 0, 1);
        // 10-bit saturating: 5 x 225 clamps to 1023
        for (int k = 0; k < 5; k++) add(1, 1, 225, 0, 1, 0, 0, 0, k, 1);
        add(1, 0, 0, 0, 1, 1, 1023, 1, 5, 0);
        add(1, 0, 0, 0, 1, 0, 1023, 1, 0, 1);
        // 10-bit wrapping: 1125 mod 1024 = 101
        for (int k = 0; k < 5; k++) add(2, 1, 225, 0, 1, 0, 0, 0, k, 1);
        add(2, 0, 0, 0, 1, 1, 101, 1, 5, 0);
        add(2, 0, 0, 0, 1, 0, 101, 1, 0, 1);
        // LEN=1: result next cycle, upstream stalled until handshake
        add(3, 1, 37, 0, 0, 0, 0, 0, 0, 1);
        add(3, 0, 0, 0, 0, 1, 37, 0, 1, 0);
        add(3, 0, 0, 0, 0, 1, 37, 0, 1, 0);
        add(3, 0, 0, 0, 1, 1, 37, 0, 1, 0);
        add(3, 0, 0, 0, 1, 0, 37, 0, 0, 1);

        foreach (vq[n]) begin
            @(negedge clk);
            en        = NI'(1 << vq[n].inst);
            in_valid  = vq[n].v;
            in_prod   = 8'(vq[n].p);
            clr       = vq[n].c;
            out_ready = vq[n].r;
            #1;
            chk($sformatf("vec%0d.out_valid", n), longint'(ov_v[vq[n].inst]), longint'(vq[n].e_ov));
            chk($sformatf("vec%0d.out_acc", n), longint'(acc_v[vq[n].inst]), longint'(vq[n].e_acc));
            chk($sformatf("vec%0d.out_ovf", n), longint'(ovf_v[vq[n].inst]), longint'(vq[n].e_ovf));
            chk($sformatf("vec%0d.beat_cnt", n), longint'(cnt_v[vq[n].inst]), longint'(vq[n].e_cnt));
            chk($sformatf("vec%0d.in_ready", n), longint'(ir_v[vq[n].inst]), longint'(vq[n].e_ir));
        end

        // Async reset between edges after three beats, then a fresh 4 x 2
        en = 4'b0001; clr = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_prod = 8'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("arst.pre_cnt", longint'(a_cnt), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.beat_cnt", longint'(a_cnt), 0);
        chk("arst.out_acc", longint'(a_acc), 0);
        chk("arst.out_valid", longint'(a_ov), 0);
        chk("arst.out_ovf", longint'(a_ovf), 0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_prod = 8'd2;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("arst.resume_valid", longint'(a_ov), 1);
        chk("arst.resume_acc", longint'(a_acc), 8);

        // Random traffic on all instances, checked by the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            en        = '1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_prod   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 40) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
